counter_strobe_driver: RTL and testbench

COUNTER_STROBE_DRIVER -- requirements
Module: counter_strobe_driver

---
 rtl/counter_pkg.sv | 17 +
 rtl/counter_strobe_driver.sv | 166 ++++++++++++++++
 tb/tb_counter_strobe_driver.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter strobe driver and its companion counter.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam int MIN_PERIOD_DEFAULT = 2;

  // True when a requested period is long enough for the counter to honour.
  function automatic logic period_ok(input logic [31:0] period, input int min_period);
    return (period >= 32'(min_period));
  endfunction

endpackage

// File: rtl/counter_strobe_driver.sv
// Drives a downstream counter: paced one-cycle enables, double-buffered
// period reload aligned to terminal count, tick counting and a watchdog
// that latches a sticky fault when the counter stops accepting enables.
module counter_strobe_driver
  import counter_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int LATENCY    = 16,
  parameter int MIN_PERIOD = MIN_PERIOD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_period,
  output logic             cfg_ready,
  output logic             cfg_err,
  input  logic             cnt_ready,
  input  logic             cnt_strobe,
  input  logic             cnt_valid,
  output logic             cnt_enable,
  output logic [WIDTH-1:0] cnt_reset_value,
  output logic             tick,
  output logic [WIDTH-1:0] tick_count,
  output logic             fault
);

  localparam int WD_W = $clog2(LATENCY + 3);
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(LATENCY + 1);
  localparam logic [WIDTH-1:0] RST_PERIOD = WIDTH'(MIN_PERIOD);

  state_t           state_r         = ST_IDLE;
  logic             cnt_enable_r    = 1'b0;
  logic             fault_r         = 1'b0;
  logic [WD_W-1:0]  wd_r            = '0;
  logic             pending_full_r  = 1'b0;
  logic [WIDTH-1:0] pending_r       = '0;
  logic [WIDTH-1:0] reset_value_r   = RST_PERIOD;
  logic             cfg_err_r       = 1'b0;
  logic             tick_r          = 1'b0;
  logic [WIDTH-1:0] tick_count_r    = '0;

  logic accept_s;
  logic good_s;
  logic load_s;
  logic qual_strobe_s;

  assign accept_s      = cfg_valid & ~pending_full_r;
  assign good_s        = period_ok(32'(cfg_period), MIN_PERIOD);
  // Outside RUN the counter is idle, so a pending period can go straight out;
  // in RUN it is only swapped at terminal count when no enable is in flight.
  assign load_s        = pending_full_r &
                         ((state_r != ST_RUN) | (cnt_strobe & ~cnt_enable_r));
  assign qual_strobe_s = cnt_strobe & cnt_valid;

  // Control FSM: state, enable pacing, watchdog and sticky fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_enable_r <= 1'b0;
      fault_r      <= 1'b0;
      wd_r         <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_enable_r <= 1'b0;
          wd_r         <= '0;
          if (run && !fault_r) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (!run) begin
            state_r      <= ST_IDLE;
            cnt_enable_r <= 1'b0;
            wd_r         <= '0;
          end else if (!cnt_ready) begin
            cnt_enable_r <= 1'b0;
            if (cnt_enable_r) begin
              wd_r <= '0;
            end else if (wd_r == WD_LAST) begin
              state_r <= ST_FAULT;
              fault_r <= 1'b1;
            end else begin
              wd_r <= wd_r + WD_W'(1);
            end
          end else begin
            // Alternate so an enable is never asserted two cycles running.
            cnt_enable_r <= ~cnt_enable_r;
            if (cnt_enable_r) begin
              wd_r <= '0;
            end else begin
              wd_r <= wd_r;
            end
          end
        end
        ST_FAULT: begin
          cnt_enable_r <= 1'b0;
          fault_r      <= 1'b1;
          state_r      <= ST_FAULT;
        end
        default: begin
          state_r      <= ST_FAULT;
          cnt_enable_r <= 1'b0;
          fault_r      <= 1'b1;
        end
      endcase
    end
  end

  // Pending period slot and rejection pulse for too-short periods.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_full_r <= 1'b0;
      pending_r      <= '0;
      cfg_err_r      <= 1'b0;
    end else begin
      cfg_err_r <= accept_s & ~good_s;
      if (accept_s && good_s) begin
        pending_full_r <= 1'b1;
        pending_r      <= cfg_period;
      end else if (load_s) begin
        pending_full_r <= 1'b0;
      end else begin
        pending_full_r <= pending_full_r;
      end
    end
  end

  // Period presented to the counter; only replaced from the pending slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      reset_value_r <= RST_PERIOD;
    end else if (load_s) begin
      reset_value_r <= pending_r;
    end else begin
      reset_value_r <= reset_value_r;
    end
  end

  // Registered tick and its free-running wrap-around count.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_r       <= 1'b0;
      tick_count_r <= '0;
    end else begin
      tick_r <= qual_strobe_s;
      if (qual_strobe_s) begin
        tick_count_r <= tick_count_r + WIDTH'(1);
      end else begin
        tick_count_r <= tick_count_r;
      end
    end
  end

  assign cfg_ready       = ~pending_full_r;
  assign cfg_err         = cfg_err_r;
  assign cnt_enable      = cnt_enable_r;
  assign cnt_reset_value = reset_value_r;
  assign tick            = tick_r;
  assign tick_count      = tick_count_r;
  assign fault           = fault_r;

endmodule

// File: tb/tb_counter_strobe_driver.sv
// Directed bench for counter_strobe_driver with WIDTH=4, LATENCY=4.
module tb_counter_strobe_driver;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         run;
  logic         cfg_valid;
  logic [W-1:0] cfg_period;
  logic         cfg_ready;
  logic         cfg_err;
  logic         cnt_ready;
  logic         cnt_strobe;
  logic         cnt_valid;
  logic         cnt_enable;
  logic [W-1:0] cnt_reset_value;
  logic         tick;
  logic [W-1:0] tick_count;
  logic         fault;

  int total = 0;
  int bad   = 0;

  counter_strobe_driver #(.WIDTH(W), .LATENCY(4), .MIN_PERIOD(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .run             (run),
    .cfg_valid       (cfg_valid),
    .cfg_period      (cfg_period),
    .cfg_ready       (cfg_ready),
    .cfg_err         (cfg_err),
    .cnt_ready       (cnt_ready),
    .cnt_strobe      (cnt_strobe),
    .cnt_valid       (cnt_valid),
    .cnt_enable      (cnt_enable),
    .cnt_reset_value (cnt_reset_value),
    .tick            (tick),
    .tick_count      (tick_count),
    .fault           (fault)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic prev_en;
    logic found;
    rst = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_period = '0;
    cnt_ready = 1'b0; cnt_strobe = 1'b0; cnt_valid = 1'b0;
    step(2);
    rst = 1'b0;
    check("rst_enable", 32'(cnt_enable), 32'd0);
    check("rst_value", 32'(cnt_reset_value), 32'd2);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_tick_count", 32'(tick_count), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);

    // Period 5 offered in IDLE reaches the counter two edges later.
    cfg_valid = 1'b1; cfg_period = 4'd5;
    step(1);
    cfg_valid = 1'b0;
    check("idle_cfg_busy", 32'(cfg_ready), 32'd0);
    check("idle_value_old", 32'(cnt_reset_value), 32'd2);
    step(1);
    check("idle_value_new", 32'(cnt_reset_value), 32'd5);
    check("idle_cfg_free", 32'(cfg_ready), 32'd1);

    // Period 1 is too short: error pulse, value untouched.
    cfg_valid = 1'b1; cfg_period = 4'd1;
    step(1);
    cfg_valid = 1'b0;
    check("err_pulse", 32'(cfg_err), 32'd1);
    check("err_cfg_ready", 32'(cfg_ready), 32'd1);
    step(1);
    check("err_pulse_end", 32'(cfg_err), 32'd0);
    check("err_value", 32'(cnt_reset_value), 32'd5);

    // Run with a ready counter: enable every other cycle.
    run = 1'b1; cnt_ready = 1'b1;
    step(1);
    check("run_first", 32'(cnt_enable), 32'd0);
    prev_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("run_pattern", 32'(cnt_enable), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("run_no_double", 32'(prev_en & cnt_enable), 32'd0);
      prev_en = cnt_enable;
    end

    // Period 7 offered mid-count waits for a strobe with no enable in flight.
    cfg_valid = 1'b1; cfg_period = 4'd7;
    step(1);
    cfg_valid = 1'b0;
    check("mid_enable", 32'(cnt_enable), 32'd1);
    check("mid_value_old", 32'(cnt_reset_value), 32'd5);
    check("mid_cfg_busy", 32'(cfg_ready), 32'd0);
    cnt_strobe = 1'b1;
    step(1);
    check("mid_hold_with_enable", 32'(cnt_reset_value), 32'd5);
    step(1);
    cnt_strobe = 1'b0;
    check("mid_value_new", 32'(cnt_reset_value), 32'd7);
    check("mid_cfg_free", 32'(cfg_ready), 32'd1);

    // Sixteen qualified strobes wrap the 4-bit tick count.
    for (int i = 0; i < 16; i++) begin
      cnt_strobe = 1'b1; cnt_valid = 1'b1;
      step(1);
      cnt_strobe = 1'b0; cnt_valid = 1'b0;
      check("tick_high", 32'(tick), 32'd1);
      check("tick_count", 32'(tick_count), 32'((i + 1) % 16));
      step(1);
      check("tick_low", 32'(tick), 32'd0);
    end
    check("tick_wrap", 32'(tick_count), 32'd0);

    // Dropping run while an enable is out: no further enables.
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      if (cnt_enable) found = 1'b1;
      else step(1);
    end
    check("stop_found_pulse", 32'(found), 32'd1);
    run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("stop_no_enable", 32'(cnt_enable), 32'd0);
    end

    // Stalled counter trips the watchdog after LATENCY+2 cycles.
    run = 1'b1;
    step(1);
    check("wd_start_enable", 32'(cnt_enable), 32'd0);
    cnt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("wd_not_yet", 32'(fault), 32'd0);
      check("wd_stall_enable", 32'(cnt_enable), 32'd0);
    end
    step(1);
    check("wd_fault", 32'(fault), 32'd1);
    cnt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("fault_no_enable", 32'(cnt_enable), 32'd0);
      check("fault_sticky", 32'(fault), 32'd1);
    end

    // In FAULT a pending period still loads straight away.
    cfg_valid = 1'b1; cfg_period = 4'd9;
    step(1);
    cfg_valid = 1'b0;
    step(1);
    check("fault_load", 32'(cnt_reset_value), 32'd9);

    // Reset with a pending period discards it.
    run = 1'b0;
    cfg_valid = 1'b1; cfg_period = 4'd6;
    step(1);
    cfg_valid = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst2_value", 32'(cnt_reset_value), 32'd2);
    check("rst2_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst2_fault", 32'(fault), 32'd0);
    step(1);
    check("rst2_pending_gone", 32'(cnt_reset_value), 32'd2);
    check("rst2_enable", 32'(cnt_enable), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
